wb_vec_stage: RTL and testbench
===============================

# wb_vec_stage

Parametrised SIMD writeback stage for the AES vector datapath. Selects one of NSRC lane-vector sources (ALU, memory, S-box, Rcon, ...) per instruction, applies a per-lane write mask and registers the result toward the vector register file. Sources with multi-cycle latency, such as a shared S-box unit, are handled through a req/ack handshake with timeout, stalling the upstream pipeline while outstanding. Sits between the MEM pipeline register and the register file write port.

## Interface
Parameters:
- LANES, 4, number of SIMD lanes
- WIDTH, 32, bits per lane
- NSRC, 4, number of selectable sources (source 0 = ALU, 1 = memory, 2 = S-box, 3 = Rcon)
- SLOW_SRC, 2, source index served through the slow handshake instead of in_src
- REGW, 5, register address width
- TIMEOUT, 16, max cycles to wait for slow_ack (≥2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction present from MEM stage
- in_ready  out  1  stage can accept; upstream holds inputs while low
- in_sel  in  $clog2(NSRC)  source select (MemToReg generalised)
- in_rd  in  REGW  destination register
- in_we  in  1  register write enable
- in_lane_mask  in  LANES  per-lane write enable
- in_src  in  NSRC*LANES*WIDTH  source s, lane l at bits [(s*LANES+l)*WIDTH +: WIDTH]
- slow_req  out  1  request to slow source
- slow_ack  in  1  slow_data valid this cycle
- slow_data  in  LANES*WIDTH  slow source result
- wb_valid  out  1  one-cycle writeback pulse
- wb_we  out  1  register file write enable
- wb_rd  out  REGW  destination register
- wb_lane_we  out  LANES  lane write enables
- wb_data  out  LANES*WIDTH  write data
- wb_err  out  1  one-cycle pulse: slow request timed out

## Operation
- States: PASS, WAIT.
- in_ready = (state == PASS).
- PASS, in_valid=1, in_sel != SLOW_SRC, in_sel < NSRC: capture selected source vector, rd, we, mask into output registers.
- PASS, in_valid=1, in_sel >= NSRC: wb_data = 0, wb_we = 0, wb_valid = 1.
- PASS, in_valid=1, in_sel == SLOW_SRC:
  - latch rd, we and mask
  - assert slow_req
  - clear the timeout counter
  - go to WAIT; no writeback this cycle
- WAIT: slow_req held at 1. Counter increments each cycle without ack.
  - slow_ack=1: capture slow_data plus the latched fields, wb_valid=1 next edge, drop slow_req, return to PASS.
  - Counter reaches TIMEOUT-1 without ack: wb_valid=1, wb_we=0, wb_data=0, wb_err=1, return to PASS.
  - Ack in the same cycle as the timeout: the ack wins; wb_err=0.
- slow_ack in PASS is ignored.
- wb_we = latched we & |mask.
- wb_lane_we = mask when wb_we=1, else 0.
- wb_data lanes are full vector regardless of mask; the register file honours wb_lane_we.
- No downstream backpressure; the register file always accepts.

## Timing
- Reset (async assert, sync release):
  - state = PASS
  - slow_req, wb_valid, wb_we, wb_err = 0
  - wb_rd, wb_lane_we, wb_data = 0
  - counter = 0
- Fast source: latency 1 (accepted at edge N, wb_valid high for cycle N+1 only).
- Slow source: accept at edge N, slow_req high from N+1. Ack seen at edge M; wb_valid high for cycle M+1; in_ready high again in cycle M+1.
- Back-to-back fast instructions: one writeback per cycle, no bubbles.
- Timeout: wb_err pulse in the same cycle as its wb_valid.
- wb_valid, wb_err deassert after one cycle unless a new instruction completes.
- Reset mid-WAIT: return to PASS, slow_req drops immediately, no writeback. A stale ack after release is ignored.

## Test plan
- Fast sources: LANES=4, sel=0 with ALU vector 0x11111111..0x44444444, rd=5, we=1, mask=4'b1111 -> next cycle wb_valid=1, wb_rd=5, wb_data equals ALU vector, wb_lane_we=4'b1111. Repeat back-to-back for sel=1, then sel=3 -> three consecutive wb_valid pulses with correct data.
- Slow source: sel=2, ack after 3 cycles with slow_data=0xA5A5A5A5 ×4 -> in_ready low 3 cycles; slow_req high 3 cycles; wb_valid pulse carrying rd and mask latched at accept.
- Timeout: TIMEOUT=16, sel=2, no ack -> after 16 cycles wb_valid=1, wb_err=1, wb_we=0, wb_data=0. Ack on the final cycle instead -> normal writeback, wb_err=0.
- Mask/enable: mask=4'b0101, we=1 -> wb_lane_we=4'b0101. mask=0 -> wb_we=0. we=0 -> wb_lane_we=0.
- Invalid select: NSRC=3, sel=3 -> wb_valid=1, wb_we=0, wb_data=0.
- Reset in WAIT: assert rst_n=0 two cycles after slow accept, release, then pulse slow_ack -> all outputs 0, no wb_valid, in_ready=1.

Source files
------------

// File: rtl/wb_vec_stage.sv
// SIMD writeback stage: picks one lane-vector source per instruction, applies the
// lane write mask and registers the result; the slow source goes through a req/ack handshake with a timeout.
module wb_vec_stage #(
    parameter int LANES    = 4,
    parameter int WIDTH    = 32,
    parameter int NSRC     = 4,
    parameter int SLOW_SRC = 2,
    parameter int REGW     = 5,
    parameter int TIMEOUT  = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [((NSRC > 1) ? $clog2(NSRC) : 1)-1:0]    in_sel,
    input  logic [REGW-1:0]                               in_rd,
    input  logic                                          in_we,
    input  logic [LANES-1:0]                              in_lane_mask,
    input  logic [NSRC*LANES*WIDTH-1:0]                   in_src,
    output logic                                          slow_req,
    input  logic                                          slow_ack,
    input  logic [LANES*WIDTH-1:0]                        slow_data,
    output logic                                          wb_valid,
    output logic                                          wb_we,
    output logic [REGW-1:0]                               wb_rd,
    output logic [LANES-1:0]                              wb_lane_we,
    output logic [LANES*WIDTH-1:0]                        wb_data,
    output logic                                          wb_err
);

    localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int VEC_W = LANES * WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic {PASS, WAIT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [REGW-1:0]    lat_rd;
    logic               lat_we;
    logic [LANES-1:0]   lat_mask;

    logic [VEC_W-1:0]   fast_vec;
    logic               sel_ok;
    logic               is_slow;
    logic               fast_en;
    logic               slow_en;

    assign in_ready = (state == PASS);
    assign is_slow  = (in_sel == SEL_W'(SLOW_SRC));
    assign fast_en  = in_we & (|in_lane_mask);
    assign slow_en  = lat_we & (|lat_mask);

    // Selects beyond NSRC have no source slice; sel_ok flags them as invalid.
    always_comb begin
        fast_vec = '0;
        sel_ok   = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (in_sel == SEL_W'(s)) begin
                fast_vec = in_src[s*VEC_W +: VEC_W];
                sel_ok   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PASS;
            wait_cnt   <= '0;
            lat_rd     <= '0;
            lat_we     <= 1'b0;
            lat_mask   <= '0;
            slow_req   <= 1'b0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= '0;
            wb_lane_we <= '0;
            wb_data    <= '0;
            wb_err     <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            wb_err     <= 1'b0;
            wb_we      <= 1'b0;
            wb_lane_we <= '0;
            case (state)
                PASS: begin
                    if (in_valid) begin
                        if (is_slow) begin
                            lat_rd   <= in_rd;
                            lat_we   <= in_we;
                            lat_mask <= in_lane_mask;
                            wait_cnt <= '0;
                            slow_req <= 1'b1;
                            state    <= WAIT;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_rd    <= in_rd;
                            if (sel_ok) begin
                                wb_data    <= fast_vec;
                                wb_we      <= fast_en;
                                wb_lane_we <= fast_en ? in_lane_mask : '0;
                            end else begin
                                wb_data <= '0;
                            end
                        end
                    end
                end
                WAIT: begin
                    // An ack arriving on the last counted cycle still completes normally.
                    if (slow_ack) begin
                        wb_valid   <= 1'b1;
                        wb_rd      <= lat_rd;
                        wb_data    <= slow_data;
                        wb_we      <= slow_en;
                        wb_lane_we <= slow_en ? lat_mask : '0;
                        slow_req   <= 1'b0;
                        state      <= PASS;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        wb_valid <= 1'b1;
                        wb_err   <= 1'b1;
                        wb_rd    <= lat_rd;
                        wb_data  <= '0;
                        slow_req <= 1'b0;
                        state    <= PASS;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_vec_stage.sv
// Testbench for wb_vec_stage: fast-source vector table, slow handshake/timeout
// sequences, invalid select on an NSRC=3 instance, and reset while waiting.
module tb_wb_vec_stage;

    localparam int LANES    = 4;
    localparam int WIDTH    = 32;
    localparam int NSRC     = 4;
    localparam int SLOW_SRC = 2;
    localparam int REGW     = 5;
    localparam int TIMEOUT  = 16;
    localparam int VEC_W    = LANES * WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                    in_valid, in_valid3, in_we, slow_ack, slow_ack3;
    logic [1:0]              in_sel;
    logic [REGW-1:0]         in_rd;
    logic [LANES-1:0]        in_lane_mask;
    logic [NSRC*VEC_W-1:0]   in_src;
    logic [3*VEC_W-1:0]      in_src3;
    logic [VEC_W-1:0]        slow_data;

    logic                    in_ready, slow_req, wb_valid, wb_we, wb_err;
    logic [REGW-1:0]         wb_rd;
    logic [LANES-1:0]        wb_lane_we;
    logic [VEC_W-1:0]        wb_data;

    logic                    in_ready3, slow_req3, wb_valid3, wb_we3, wb_err3;
    logic [REGW-1:0]         wb_rd3;
    logic [LANES-1:0]        wb_lane_we3;
    logic [VEC_W-1:0]        wb_data3;

    wb_vec_stage #(.LANES(LANES), .WIDTH(WIDTH), .NSRC(NSRC), .SLOW_SRC(SLOW_SRC),
                   .REGW(REGW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_rd(in_rd), .in_we(in_we), .in_lane_mask(in_lane_mask),
        .in_src(in_src), .slow_req(slow_req), .slow_ack(slow_ack), .slow_data(slow_data),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_lane_we(wb_lane_we),
        .wb_data(wb_data), .wb_err(wb_err)
    );

    wb_vec_stage #(.LANES(LANES), .WIDTH(WIDTH), .NSRC(3), .SLOW_SRC(SLOW_SRC),
                   .REGW(REGW), .TIMEOUT(TIMEOUT)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_sel(in_sel), .in_rd(in_rd), .in_we(in_we), .in_lane_mask(in_lane_mask),
        .in_src(in_src3), .slow_req(slow_req3), .slow_ack(slow_ack3), .slow_data(slow_data),
        .wb_valid(wb_valid3), .wb_we(wb_we3), .wb_rd(wb_rd3), .wb_lane_we(wb_lane_we3),
        .wb_data(wb_data3), .wb_err(wb_err3)
    );

    typedef struct {
        logic                  valid;
        logic [1:0]            sel;
        logic [REGW-1:0]       rd;
        logic                  we;
        logic [LANES-1:0]      mask;
        logic [NSRC*VEC_W-1:0] src;
        logic                  exp_valid;
        logic                  exp_we;
        logic [REGW-1:0]       exp_rd;
        logic [LANES-1:0]      exp_lane_we;
        logic [VEC_W-1:0]      exp_data;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [VEC_W-1:0] act,
                               input logic [VEC_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [VEC_W-1:0] rndVec();
        logic [VEC_W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = $urandom;
        return v;
    endfunction

    // Reference: the destination gets the selected source (zero if no such source),
    // and writes only when enabled with at least one lane set.
    function automatic vec_t refModel(input vec_t v, input int nsrc);
        vec_t r;
        logic [VEC_W-1:0] srcs [NSRC];
        bit en;
        r = v;
        for (int s = 0; s < NSRC; s++) srcs[s] = v.src[s*VEC_W +: VEC_W];
        en            = (v.we == 1'b1) && (v.mask != '0) && (int'(v.sel) < nsrc);
        r.exp_valid   = v.valid;
        r.exp_rd      = v.rd;
        r.exp_data    = (int'(v.sel) < nsrc) ? srcs[v.sel] : '0;
        r.exp_we      = en;
        r.exp_lane_we = en ? v.mask : '0;
        return r;
    endfunction

    function automatic vec_t mkVec(input logic [1:0] sel, input logic [REGW-1:0] rd,
                                   input logic we, input logic [LANES-1:0] mask,
                                   input logic [NSRC*VEC_W-1:0] src, input logic ewe,
                                   input logic [LANES-1:0] elane, input logic [VEC_W-1:0] edata);
        vec_t v;
        v.valid = 1'b1; v.sel = sel; v.rd = rd; v.we = we; v.mask = mask; v.src = src;
        v.exp_valid = 1'b1; v.exp_we = ewe; v.exp_rd = rd; v.exp_lane_we = elane;
        v.exp_data = edata;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        in_valid     = v.valid;
        in_sel       = v.sel;
        in_rd        = v.rd;
        in_we        = v.we;
        in_lane_mask = v.mask;
        in_src       = v.src;
    endtask

    task automatic checkVec(input vec_t v, input int idx);
        checkOutput($sformatf("vec%0d.wb_valid", idx), VEC_W'(wb_valid), VEC_W'(v.exp_valid));
        checkOutput($sformatf("vec%0d.wb_err", idx), VEC_W'(wb_err), '0);
        if (v.exp_valid) begin
            checkOutput($sformatf("vec%0d.wb_we", idx), VEC_W'(wb_we), VEC_W'(v.exp_we));
            checkOutput($sformatf("vec%0d.wb_rd", idx), VEC_W'(wb_rd), VEC_W'(v.exp_rd));
            checkOutput($sformatf("vec%0d.wb_lane_we", idx), VEC_W'(wb_lane_we),
                        VEC_W'(v.exp_lane_we));
            checkOutput($sformatf("vec%0d.wb_data", idx), wb_data, v.exp_data);
        end
    endtask

    // ack_delay = cycle (counted from the first slow_req cycle) in which ack is driven;
    // 0 or anything past TIMEOUT means no ack, which must end in a timeout.
    task automatic runSlow(input logic [REGW-1:0] rd, input logic we,
                           input logic [LANES-1:0] mask, input int ack_delay,
                           input logic [VEC_W-1:0] data, input string tag);
        int stall;
        bit got;
        bit timed_out;
        bit en;
        int exp_lat;
        stall     = 0;
        got       = 1'b0;
        timed_out = (ack_delay < 1) || (ack_delay > TIMEOUT);
        exp_lat   = timed_out ? TIMEOUT : ack_delay;
        en        = !timed_out && (we == 1'b1) && (mask != '0);
        in_valid = 1'b1; in_sel = 2'(SLOW_SRC); in_rd = rd; in_we = we;
        in_lane_mask = mask; in_src = {rndVec(), rndVec(), rndVec(), rndVec()};
        step();
        in_valid = 1'b0; in_rd = REGW'($urandom); in_we = 1'($urandom);
        in_lane_mask = LANES'($urandom);
        for (int k = 1; k <= TIMEOUT + 4; k++) begin
            if (wb_valid) begin
                got = 1'b1;
                break;
            end
            if (!in_ready && slow_req) stall++;
            slow_ack  = (k == ack_delay);
            slow_data = (k == ack_delay) ? data : rndVec();
            step();
        end
        slow_ack = 1'b0;
        checkOutput({tag, ".completed"}, VEC_W'(got), VEC_W'(1));
        checkOutput({tag, ".stall_cycles"}, VEC_W'(stall), VEC_W'(exp_lat));
        checkOutput({tag, ".in_ready"}, VEC_W'(in_ready), VEC_W'(1));
        checkOutput({tag, ".slow_req"}, VEC_W'(slow_req), '0);
        checkOutput({tag, ".wb_err"}, VEC_W'(wb_err), VEC_W'(timed_out));
        checkOutput({tag, ".wb_we"}, VEC_W'(wb_we), VEC_W'(en));
        checkOutput({tag, ".wb_lane_we"}, VEC_W'(wb_lane_we), en ? VEC_W'(mask) : '0);
        checkOutput({tag, ".wb_data"}, wb_data, timed_out ? '0 : data);
        if (!timed_out) checkOutput({tag, ".wb_rd"}, VEC_W'(wb_rd), VEC_W'(rd));
        step();
        checkOutput({tag, ".wb_valid_drop"}, VEC_W'(wb_valid), '0);
        checkOutput({tag, ".wb_err_drop"}, VEC_W'(wb_err), '0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [VEC_W-1:0] alu, mem, sbox, rcon;
        logic [NSRC*VEC_W-1:0] src;
        logic [1:0] picks [3];
        vec_t v;

        in_valid = 1'b0; in_valid3 = 1'b0; in_sel = '0; in_rd = '0; in_we = 1'b0;
        in_lane_mask = '0; in_src = '0; in_src3 = '0; slow_ack = 1'b0; slow_ack3 = 1'b0;
        slow_data = '0;
        repeat (2) step();
        checkOutput("reset.in_ready", VEC_W'(in_ready), VEC_W'(1));
        checkOutput("reset.slow_req", VEC_W'(slow_req), '0);
        checkOutput("reset.wb_valid", VEC_W'(wb_valid), '0);
        checkOutput("reset.wb_we", VEC_W'(wb_we), '0);
        checkOutput("reset.wb_err", VEC_W'(wb_err), '0);
        checkOutput("reset.wb_rd", VEC_W'(wb_rd), '0);
        checkOutput("reset.wb_lane_we", VEC_W'(wb_lane_we), '0);
        checkOutput("reset.wb_data", wb_data, '0);
        rst_n = 1'b1;
        step();

        alu  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        mem  = {32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
        sbox = rndVec();
        rcon = {32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000};
        src  = {rcon, sbox, mem, alu};

        vecs.push_back(mkVec(2'd0, 5'd5,  1'b1, 4'b1111, src, 1'b1, 4'b1111, alu));
        vecs.push_back(mkVec(2'd1, 5'd6,  1'b1, 4'b1111, src, 1'b1, 4'b1111, mem));
        vecs.push_back(mkVec(2'd3, 5'd7,  1'b1, 4'b1111, src, 1'b1, 4'b1111, rcon));
        vecs.push_back(mkVec(2'd0, 5'd8,  1'b1, 4'b0101, src, 1'b1, 4'b0101, alu));
        vecs.push_back(mkVec(2'd1, 5'd9,  1'b1, 4'b0000, src, 1'b0, 4'b0000, mem));
        vecs.push_back(mkVec(2'd3, 5'd10, 1'b0, 4'b1111, src, 1'b0, 4'b0000, rcon));
        v = mkVec(2'd0, 5'd11, 1'b1, 4'b1111, src, 1'b0, 4'b0000, '0);
        v.valid = 1'b0; v.exp_valid = 1'b0;
        vecs.push_back(v);

        picks[0] = 2'd0; picks[1] = 2'd1; picks[2] = 2'd3;
        for (int i = 0; i < 40; i++) begin
            v.valid = ($urandom_range(0, 3) != 0);
            v.sel   = picks[$urandom_range(0, 2)];
            v.rd    = REGW'($urandom);
            v.we    = ($urandom_range(0, 4) != 0);
            v.mask  = LANES'($urandom);
            v.src   = {rndVec(), rndVec(), rndVec(), rndVec()};
            vecs.push_back(refModel(v, NSRC));
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            step();
            checkVec(vecs[i], i);
        end
        in_valid = 1'b0;
        step();

        slow_ack = 1'b1;
        slow_data = rndVec();
        step();
        slow_ack = 1'b0;
        checkOutput("pass_ack.wb_valid", VEC_W'(wb_valid), '0);
        checkOutput("pass_ack.in_ready", VEC_W'(in_ready), VEC_W'(1));
        checkOutput("pass_ack.slow_req", VEC_W'(slow_req), '0);

        runSlow(5'd12, 1'b1, 4'b1111, 3, {4{32'hA5A5A5A5}}, "slow_ack3");
        runSlow(5'd13, 1'b1, 4'b1111, 0, rndVec(), "slow_timeout");
        runSlow(5'd14, 1'b1, 4'b0110, TIMEOUT, rndVec(), "slow_ack_last");
        runSlow(5'd15, 1'b1, 4'b0101, 1, rndVec(), "slow_ack1");
        runSlow(5'd16, 1'b0, 4'b1111, 2, rndVec(), "slow_we0");
        for (int i = 0; i < 5; i++) begin
            runSlow(REGW'($urandom), 1'($urandom), LANES'($urandom),
                    $urandom_range(0, TIMEOUT + 2), rndVec(), $sformatf("slow_rnd%0d", i));
        end

        in_valid3 = 1'b1; in_sel = 2'd3; in_rd = 5'd9; in_we = 1'b1; in_lane_mask = 4'b1111;
        in_src3 = {rndVec(), rndVec(), rndVec()};
        step();
        in_valid3 = 1'b0;
        checkOutput("badsel.wb_valid", VEC_W'(wb_valid3), VEC_W'(1));
        checkOutput("badsel.wb_we", VEC_W'(wb_we3), '0);
        checkOutput("badsel.wb_lane_we", VEC_W'(wb_lane_we3), '0);
        checkOutput("badsel.wb_data", wb_data3, '0);
        checkOutput("badsel.wb_err", VEC_W'(wb_err3), '0);
        in_valid3 = 1'b1; in_sel = 2'd1; in_rd = 5'd4;
        step();
        in_valid3 = 1'b0;
        checkOutput("nsrc3_sel1.wb_data", wb_data3, in_src3[VEC_W +: VEC_W]);
        checkOutput("nsrc3_sel1.wb_rd", VEC_W'(wb_rd3), VEC_W'(4));
        step();
        checkOutput("nsrc3.wb_valid_drop", VEC_W'(wb_valid3), '0);

        in_valid = 1'b1; in_sel = 2'(SLOW_SRC); in_rd = 5'd3; in_we = 1'b1;
        in_lane_mask = 4'b1111;
        step();
        in_valid = 1'b0;
        step();
        step();
        checkOutput("rstwait.slow_req_before", VEC_W'(slow_req), VEC_W'(1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstwait.slow_req_async", VEC_W'(slow_req), '0);
        checkOutput("rstwait.in_ready_async", VEC_W'(in_ready), VEC_W'(1));
        step();
        step();
        rst_n = 1'b1;
        slow_ack = 1'b1;
        slow_data = rndVec();
        step();
        slow_ack = 1'b0;
        checkOutput("rstwait.wb_valid", VEC_W'(wb_valid), '0);
        checkOutput("rstwait.in_ready", VEC_W'(in_ready), VEC_W'(1));
        checkOutput("rstwait.slow_req", VEC_W'(slow_req), '0);
        checkOutput("rstwait.wb_we", VEC_W'(wb_we), '0);
        checkOutput("rstwait.wb_err", VEC_W'(wb_err), '0);
        checkOutput("rstwait.wb_rd", VEC_W'(wb_rd), '0);
        checkOutput("rstwait.wb_lane_we", VEC_W'(wb_lane_we), '0);
        checkOutput("rstwait.wb_data", wb_data, '0);
        step();
        checkOutput("rstwait.wb_valid_later", VEC_W'(wb_valid), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
